// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg
// Shared types and widths for the PLL lock sequencer.
//   pll_seq_state_t : sequencer state encoding
//   RETRY_W         : width of the failed-attempt counter
//   RELOCK_W        : width of the relock counter (used when PLL_SEQ_RELOCK_EN is defined)
//   max3            : helper used to size the shared timer
package pll_seq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } pll_seq_state_t;

    localparam int RETRY_W  = 8;
    localparam int RELOCK_W = 16;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Generic two-flop synchronizer for bringing asynchronous level signals into
// the clk domain. Both stages clear on reset so the synchronized value starts low.
// Ports:
//   clk   : destination clock
//   rst_n : synchronous active-low reset
//   d     : asynchronous input
//   q     : synchronized output (two cycles of latency)
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
// Power-up and recovery sequencer for the rPLL generating the LCD pixel clock.
// Pulses the PLL RESET pin, waits for LOCK, requires LOCK to be continuously
// high for STABLE_CYCLES before releasing the pixel-domain reset, and retries a
// bounded number of times before latching a fault.
//
// Optional feature macro: PLL_SEQ_RELOCK_EN
//   defined   : lock loss in RUN restarts the sequence and bumps relock_cnt_o
//   undefined : lock loss in RUN goes straight to FAULT; no relock_cnt_o port
//
// Ports:
//   sys_clk        : 27 MHz free-running clock
//   sys_rst_n      : synchronous active-low reset
//   pll_lock_i     : rPLL LOCK (asynchronous)
//   retry_i        : single-cycle pulse, leaves FAULT and restarts the sequence
//   pll_reset_o    : rPLL RESET, high in RESET_PLL and FAULT
//   domain_rst_n_o : active-low downstream reset, high only in RUN
//   locked_o       : high only in RUN
//   fault_o        : high only in FAULT
//   retry_cnt_o    : failed attempts since last success or reset
//   relock_cnt_o   : saturating count of lock losses in RUN (PLL_SEQ_RELOCK_EN only)
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 27000,
    parameter int STABLE_CYCLES = 2700,
    parameter int MAX_RETRIES   = 3
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               pll_lock_i,
    input  logic               retry_i,
    output logic               pll_reset_o,
    output logic               domain_rst_n_o,
    output logic               locked_o,
    output logic               fault_o,
    output logic [RETRY_W-1:0] retry_cnt_o
`ifdef PLL_SEQ_RELOCK_EN
    ,
    output logic [RELOCK_W-1:0] relock_cnt_o
`endif
);

    localparam int TIMER_MAX = max3(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES);
    localparam int TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;

    localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    function automatic logic [RETRY_W-1:0] sat_inc_retry(input logic [RETRY_W-1:0] v);
        return (v == {RETRY_W{1'b1}}) ? v : v + RETRY_W'(1);
    endfunction

`ifdef PLL_SEQ_RELOCK_EN
    function automatic logic [RELOCK_W-1:0] sat_inc_relock(input logic [RELOCK_W-1:0] v);
        return (v == {RELOCK_W{1'b1}}) ? v : v + RELOCK_W'(1);
    endfunction

    logic [RELOCK_W-1:0] relock_cnt;
    logic [RELOCK_W-1:0] relock_nx;
`endif

    pll_seq_state_t     state;
    pll_seq_state_t     state_nx;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_nx;
    logic [RETRY_W-1:0] retry_cnt;
    logic [RETRY_W-1:0] retry_nx;
    logic               fail;
    logic               lock_s;

    sync_2ff #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk  (sys_clk),
        .rst_n(sys_rst_n),
        .d    (pll_lock_i),
        .q    (lock_s)
    );

    always_comb begin
        state_nx = state;
        retry_nx = retry_cnt;
        fail     = 1'b0;
`ifdef PLL_SEQ_RELOCK_EN
        relock_nx = relock_cnt;
`endif
        case (state)
            RESET_PLL: begin
                if (timer == RST_LAST) state_nx = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s)                     state_nx = STABLE;
                else if (timer == TIMEOUT_LAST) fail     = 1'b1;
            end
            STABLE: begin
                // A drop of lock_s takes priority over a completed stability window.
                if (!lock_s) begin
                    fail = 1'b1;
                end else if (timer == STABLE_LAST) begin
                    state_nx = RUN;
                    retry_nx = '0;
                end
            end
            RUN: begin
                if (!lock_s) begin
`ifdef PLL_SEQ_RELOCK_EN
                    // A clean run earns back full retries, so retry_cnt is left alone.
                    state_nx  = RESET_PLL;
                    relock_nx = sat_inc_relock(relock_cnt);
`else
                    state_nx = FAULT;
`endif
                end
            end
            FAULT: begin
                if (retry_i) begin
                    state_nx = RESET_PLL;
                    retry_nx = '0;
                end
            end
            default: state_nx = RESET_PLL;
        endcase

        if (fail) begin
            retry_nx = sat_inc_retry(retry_cnt);
            state_nx = (retry_nx == RETRY_LIMIT) ? FAULT : RESET_PLL;
        end

        // Single shared timer: cleared on every state change, idle in RUN and FAULT.
        if ((state_nx != state) || (state == RUN) || (state == FAULT)) timer_nx = '0;
        else                                                           timer_nx = timer + TIMER_W'(1);
    end

    // Outputs are decoded from the next state so they settle on the same edge
    // that commits the transition.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state          <= RESET_PLL;
            timer          <= '0;
            retry_cnt      <= '0;
            pll_reset_o    <= 1'b1;
            domain_rst_n_o <= 1'b0;
            locked_o       <= 1'b0;
            fault_o        <= 1'b0;
`ifdef PLL_SEQ_RELOCK_EN
            relock_cnt     <= '0;
`endif
        end else begin
            state          <= state_nx;
            timer          <= timer_nx;
            retry_cnt      <= retry_nx;
            pll_reset_o    <= (state_nx == RESET_PLL) || (state_nx == FAULT);
            domain_rst_n_o <= (state_nx == RUN);
            locked_o       <= (state_nx == RUN);
            fault_o        <= (state_nx == FAULT);
`ifdef PLL_SEQ_RELOCK_EN
            relock_cnt     <= relock_nx;
`endif
        end
    end

    assign retry_cnt_o = retry_cnt;
`ifdef PLL_SEQ_RELOCK_EN
    assign relock_cnt_o = relock_cnt;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer
// Directed bench for pll_lock_sequencer with RST_CYCLES=4, LOCK_TIMEOUT=20,
// STABLE_CYCLES=10, MAX_RETRIES=3. The stimulus process queues expected output
// snapshots tagged with the clock cycle they apply to; a monitor on the falling
// edge pops and compares them.
module tb_pll_lock_sequencer;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 10;
    localparam int MAX_RETRIES   = 3;

    logic        sys_clk    = 1'b0;
    logic        sys_rst_n  = 1'b0;
    logic        pll_lock_i = 1'b0;
    logic        retry_i    = 1'b0;
    logic        pll_reset_o;
    logic        domain_rst_n_o;
    logic        locked_o;
    logic        fault_o;
    logic [7:0]  retry_cnt_o;
`ifdef PLL_SEQ_RELOCK_EN
    logic [15:0] relock_cnt_o;
`endif

    pll_lock_sequencer #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRIES  (MAX_RETRIES)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .pll_lock_i    (pll_lock_i),
        .retry_i       (retry_i),
        .pll_reset_o   (pll_reset_o),
        .domain_rst_n_o(domain_rst_n_o),
        .locked_o      (locked_o),
        .fault_o       (fault_o),
        .retry_cnt_o   (retry_cnt_o)
`ifdef PLL_SEQ_RELOCK_EN
        ,
        .relock_cnt_o  (relock_cnt_o)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    // cyc equals the number of rising edges seen so far.
    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        string      name;
        int         cyc;
        logic       pr;
        logic       dr;
        logic       lk;
        logic       ft;
        logic [7:0] rc;
        int         rl;      // expected relock count, -1 = don't care
        bit         chk_lat;
        int         lat;
        int         lo;
        int         hi;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic push_exp(input string name, input int c, input logic pr, input logic dr,
                            input logic lk, input logic ft, input logic [7:0] rc, input int rl);
        exp_t e;
        e.name = name; e.cyc = c; e.pr = pr; e.dr = dr; e.lk = lk; e.ft = ft;
        e.rc = rc; e.rl = rl; e.chk_lat = 1'b0; e.lat = 0; e.lo = 0; e.hi = 0;
        sb.push_back(e);
    endtask

    task automatic push_lat(input string name, input int c, input logic pr, input logic dr,
                            input logic lk, input logic ft, input logic [7:0] rc,
                            input int lat, input int lo, input int hi);
        exp_t e;
        e.name = name; e.cyc = c; e.pr = pr; e.dr = dr; e.lk = lk; e.ft = ft;
        e.rc = rc; e.rl = -1; e.chk_lat = 1'b1; e.lat = lat; e.lo = lo; e.hi = hi;
        sb.push_back(e);
    endtask

    // Monitor: compares every queued snapshot due at the current cycle.
    exp_t m_e;
    bit   m_ok;
    bit   m_rl_ok;
    always @(negedge sys_clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            m_e = sb.pop_front();
            total++;
            if (m_e.cyc < cyc) begin
                bad++;
                $display("FAIL %s: snapshot for cycle %0d not compared (now %0d)", m_e.name, m_e.cyc, cyc);
            end else begin
`ifdef PLL_SEQ_RELOCK_EN
                m_rl_ok = (m_e.rl < 0) || (relock_cnt_o == 16'(m_e.rl));
`else
                m_rl_ok = 1'b1;
`endif
                m_ok = (pll_reset_o === m_e.pr) && (domain_rst_n_o === m_e.dr) &&
                       (locked_o === m_e.lk) && (fault_o === m_e.ft) &&
                       (retry_cnt_o === m_e.rc) && m_rl_ok &&
                       (!m_e.chk_lat || (m_e.lat >= m_e.lo && m_e.lat <= m_e.hi));
                if (!m_ok) begin
                    bad++;
                    $display("FAIL %s @%0d: got pr=%b dr=%b lk=%b ft=%b rc=%0d lat=%0d relock_ok=%0b, want pr=%b dr=%b lk=%b ft=%b rc=%0d lat=[%0d..%0d] relock=%0d",
                             m_e.name, cyc, pll_reset_o, domain_rst_n_o, locked_o, fault_o, retry_cnt_o,
                             m_e.lat, m_rl_ok, m_e.pr, m_e.dr, m_e.lk, m_e.ft, m_e.rc, m_e.lo, m_e.hi, m_e.rl);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic goto_cyc(input int c);
        while (cyc < c) step(1);
    endtask

    // Hold reset for three edges; p is the last cycle that sampled reset low.
    task automatic do_reset(output int p);
        sys_rst_n = 1'b0;
        step(3);
        p = cyc;
        push_exp("rst_values", p, 1, 0, 0, 0, 0, 0);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        int p;
        int t;
        int q;
        int c;

        // ---- Power-up, lock raised two cycles after reset release ----
        pll_lock_i = 1'b0;
        do_reset(p);
        push_exp("pwr_first_cycle", p + 1, 1, 0, 0, 0, 0, 0);
        push_exp("pwr_wait_lock",   p + 4, 0, 0, 0, 0, 0, 0);
        goto_cyc(p + 2);
        pll_lock_i = 1'b1;
        t = -1;
        for (int k = 0; k < 60; k++) begin
            step(1);
            if (domain_rst_n_o === 1'b1) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            total++;
            bad++;
            $display("FAIL pwr_run: domain_rst_n_o still low 60 cycles after release, want high by %0d",
                     RST_CYCLES + 3 + STABLE_CYCLES + 2);
            t = cyc;
        end else begin
            // Lock rises during RESET_PLL, so the synchronizer latency is hidden and
            // release can come as early as RST + 1 + STABLE; the nominal figure is
            // RST + 3 + STABLE + 1 with one cycle of slack.
            push_lat("pwr_run", t, 0, 1, 1, 0, 0, t - p,
                     RST_CYCLES + 1 + STABLE_CYCLES, RST_CYCLES + 3 + STABLE_CYCLES + 2);
        end
        q = t;

        // retry_i in RUN is ignored
        push_exp("run_retry_ignored", q + 3, 0, 1, 1, 0, 0, 0);
        goto_cyc(q + 1);
        retry_i = 1'b1;
        goto_cyc(q + 2);
        retry_i = 1'b0;

        // Lock loss in RUN: reset domain three cycles after the pin drops
        c = q + 4;
        push_exp("loss_still_run", c + 2, 0, 1, 1, 0, 0, 0);
`ifdef PLL_SEQ_RELOCK_EN
        push_exp("loss_relock",    c + 3,  1, 0, 0, 0, 0, 1);
        push_exp("relock_wait",    c + 7,  0, 0, 0, 0, 0, 1);
        push_exp("relock_stable",  c + 17, 0, 0, 0, 0, 0, 1);
        push_exp("relock_run",     c + 18, 0, 1, 1, 0, 0, 1);
        goto_cyc(c);
        pll_lock_i = 1'b0;
        goto_cyc(c + 3);
        pll_lock_i = 1'b1;
        goto_cyc(c + 19);
`else
        push_exp("loss_fault",     c + 3, 1, 0, 0, 1, 0, -1);
        push_exp("loss_fault_hold", c + 8, 1, 0, 0, 1, 0, -1);
        goto_cyc(c);
        pll_lock_i = 1'b0;
        goto_cyc(c + 9);
`endif

        // ---- Lock never asserted: three failed attempts then FAULT ----
        pll_lock_i = 1'b0;
        do_reset(p);
        push_exp("nl_wait1",          p + 4,  0, 0, 0, 0, 0, 0);
        push_exp("nl_wait1_last",     p + 23, 0, 0, 0, 0, 0, 0);
        push_exp("nl_fail1",          p + 24, 1, 0, 0, 0, 1, 0);
        push_exp("nl_wait2",          p + 28, 0, 0, 0, 0, 1, 0);
        push_exp("wait_retry_ignored", p + 32, 0, 0, 0, 0, 1, 0);
        push_exp("nl_wait2_last",     p + 47, 0, 0, 0, 0, 1, 0);
        push_exp("nl_fail2",          p + 48, 1, 0, 0, 0, 2, 0);
        push_exp("nl_wait3_last",     p + 71, 0, 0, 0, 0, 2, 0);
        push_exp("nl_fault",          p + 72, 1, 0, 0, 1, 3, 0);
        push_exp("nl_fault_hold",     p + 80, 1, 0, 0, 1, 3, 0);
        goto_cyc(p + 30);
        retry_i = 1'b1;
        goto_cyc(p + 31);
        retry_i = 1'b0;
        goto_cyc(p + 80);
        retry_i = 1'b1;
        push_exp("fault_retry",       p + 81, 1, 0, 0, 0, 0, 0);
        push_exp("retry_rst_last",    p + 84, 1, 0, 0, 0, 0, 0);
        push_exp("retry_wait_lock",   p + 85, 0, 0, 0, 0, 0, 0);
        goto_cyc(p + 81);
        retry_i = 1'b0;
        goto_cyc(p + 86);

        // ---- One-cycle lock glitch during STABLE ----
        pll_lock_i = 1'b1;
        do_reset(p);
        push_exp("gl_stable",     p + 5,  0, 0, 0, 0, 0, 0);
        push_exp("gl_pre_fail",   p + 11, 0, 0, 0, 0, 0, 0);
        push_exp("gl_fail",       p + 12, 1, 0, 0, 0, 1, 0);
        push_exp("gl_rst_last",   p + 15, 1, 0, 0, 0, 1, 0);
        push_exp("gl_wait",       p + 16, 0, 0, 0, 0, 1, 0);
        push_exp("gl_pre_run",    p + 26, 0, 0, 0, 0, 1, 0);
        push_exp("gl_run",        p + 27, 0, 1, 1, 0, 0, 0);
        goto_cyc(p + 9);
        pll_lock_i = 1'b0;
        goto_cyc(p + 10);
        pll_lock_i = 1'b1;
        goto_cyc(p + 28);

        // ---- One-cycle reset while in STABLE ----
        do_reset(p);
        push_exp("mr_stable",     p + 8,  0, 0, 0, 0, 0, 0);
        push_exp("mr_reset",      p + 9,  1, 0, 0, 0, 0, 0);
        push_exp("mr_first",      p + 10, 1, 0, 0, 0, 0, 0);
        push_exp("mr_rst_last",   p + 12, 1, 0, 0, 0, 0, 0);
        push_exp("mr_wait",       p + 13, 0, 0, 0, 0, 0, 0);
        push_exp("mr_pre_run",    p + 23, 0, 0, 0, 0, 0, 0);
        push_exp("mr_run",        p + 24, 0, 1, 1, 0, 0, 0);
        goto_cyc(p + 8);
        sys_rst_n = 1'b0;
        goto_cyc(p + 9);
        sys_rst_n = 1'b1;
        goto_cyc(p + 26);

        // Drain the scoreboard with a bound.
        for (int k = 0; k < 5 && sb.size() > 0; k++) step(1);
        while (sb.size() > 0) begin
            m_e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL %s: snapshot for cycle %0d never compared", m_e.name, m_e.cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
